// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-back path.
// Used by the scheduler and anything else that addresses the 32-entry file.
package regfile_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, priority rotates past the last winner.
// Latency: grant is combinational; rotation state updates on the grant edge.
// Backpressure: requesters not granted simply wait; no grant leaves state unchanged.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [IW-1:0] last_grant;
    int            cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        // Scan starts one past the previous winner so every requester gets a turn.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= IW'(NREQ - 1);
        end else if (gnt_vld) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler + busy scoreboard for the 32x32 register file (REGFILE_WB_BYPASS_EN: same-cycle release).
// Latency: grant combinational, register-file write staged one cycle later.
// Backpressure: one write-back per cycle via round-robin req_ready; WAW reservations stall on busy.
module regfile_wb_sched #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ready,
    input  logic [AW-1:0]    chk_addr1,
    input  logic [AW-1:0]    chk_addr2,
    output logic             chk_busy1,
    output logic             chk_busy2,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    output logic             rf_we,
    output logic [AW-1:0]    rf_wa,
    output logic [DW-1:0]    rf_wd
);
    import regfile_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req_live;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_chk;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    // Masking with reset keeps grants (and thus consumed requests) off while in reset.
    assign req_live = req_valid & {NREQ{rst}};

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_live),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = gnt;
    assign gnt_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data  = req_data[int'(gnt_idx)*DW +: DW];

    always_comb begin
        clr_mask = '0;
        if (gnt_vld) begin
            clr_mask[gnt_addr] = 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign busy_chk = busy & ~clr_mask & ~NREG'(1);
`else
    assign busy_chk = busy;
`endif

    assign chk_busy1 = busy_chk[chk_addr1];
    assign chk_busy2 = busy_chk[chk_addr2];
    assign rsv_ready = rsv_valid && ((rsv_addr == '0) || !busy_chk[rsv_addr]);

    always_comb begin
        set_mask = '0;
        if (rsv_ready && (rsv_addr != '0)) begin
            set_mask[rsv_addr] = 1'b1;
        end
        // A fresh reservation wins over a release of the same register.
        busy_nxt = ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= '0;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            busy  <= busy_nxt;
            rf_we <= gnt_vld && (gnt_addr != '0);
            if (gnt_vld) begin
                rf_wa <= gnt_addr;
                rf_wd <= gnt_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected write-backs are queued at grant time
// and compared against the staged register-file write one cycle later.
module tb_regfile_wb_sched;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    logic             clk;
    logic             rst;
    logic             rsv_valid;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_ready;
    logic [AW-1:0]    chk_addr1;
    logic [AW-1:0]    chk_addr2;
    logic             chk_busy1;
    logic             chk_busy2;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             rf_we;
    logic [AW-1:0]    rf_wa;
    logic [DW-1:0]    rf_wd;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];

    regfile_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and compare the staged write against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", rf_we, e.we);
            chk("rf_wa", rf_wa, e.wa);
            chk("rf_wd", rf_wd, e.wd);
        end else begin
            chk("rf_we_idle", rf_we, 1'b0);
        end
    endtask

    task automatic wb(input logic [1:0] vld, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [1:0] exp_gnt);
        req_valid = vld;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #2;
        chk("grant", req_ready, exp_gnt);
        if (exp_gnt == 2'b01) exp_q.push_back(wr_t'{we: (a0 != '0), wa: a0, wd: d0});
        else if (exp_gnt == 2'b10) exp_q.push_back(wr_t'{we: (a1 != '0), wa: a1, wd: d1});
    endtask

    initial begin
        rst = 1'b0; rsv_valid = 1'b0; rsv_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
        req_valid = '0; req_addr = '0; req_data = '0;

        // Reset with random activity on the inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            rsv_valid = 1'($urandom); rsv_addr = AW'($urandom);
            req_addr  = ($urandom); req_data = {$urandom, $urandom};
            req_valid = 2'b11;
        end
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wa", rf_wa, '0);
        chk("rst_rf_wd", rf_wd, '0);
        chk("rst_req_ready", req_ready, 2'b00);
        for (int a = 0; a < 32; a++) begin
            chk_addr1 = AW'(a);
            #1;
            chk("rst_busy", chk_busy1, 1'b0);
        end
        rsv_valid = 1'b0; rsv_addr = '0; req_valid = '0; req_addr = '0; req_data = '0;
        chk_addr1 = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Round-robin fairness, then requester 1 alone
        wb(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2, 2'b01); tick();
        wb(2'b11, 5'd3, 32'hA3, 5'd2, 32'hB2, 2'b10); tick();
        wb(2'b11, 5'd3, 32'hA3, 5'd4, 32'hB4, 2'b01); tick();
        wb(2'b11, 5'd6, 32'hA6, 5'd4, 32'hB4, 2'b10); tick();
        wb(2'b10, 5'd0, 32'h0,  5'd8, 32'hB8, 2'b10); tick();
        chk_addr1 = 5'd4;
        #1;
        chk("nonbusy_r4", chk_busy1, 1'b0);

        // Reserve r5 then write it
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        chk("rsv_r5", rsv_ready, 1'b1);
        tick();
        rsv_valid = 1'b0; chk_addr1 = 5'd5;
        wb(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01);
        chk("busy_r5_grant_cycle", chk_busy1, !BYP);
        tick();
        chk("busy_r5_after", chk_busy1, 1'b0);

        // WAW stall on r7
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        chk("rsv_r7", rsv_ready, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
            chk("waw_stall", rsv_ready, 1'b0);
            tick();
        end
        wb(2'b10, 5'd0, 32'h0, 5'd7, 32'h77, 2'b10);
        chk("waw_grant_cycle", rsv_ready, BYP);
        tick();
        wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        chk("waw_after", rsv_ready, !BYP);
        tick();
        rsv_valid = 1'b0; chk_addr1 = 5'd7;
        #1;
        chk("busy_r7_rereserved", chk_busy1, 1'b1);

        // Grant of r7 together with reservation of r9
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        wb(2'b01, 5'd7, 32'h7777, 5'd0, 32'h0, 2'b01);
        chk("rsv_r9_with_grant", rsv_ready, 1'b1);
        tick();
        rsv_valid = 1'b0; chk_addr1 = 5'd7; chk_addr2 = 5'd9;
        #1;
        chk("busy_r7_cleared", chk_busy1, 1'b0);
        chk("busy_r9_set", chk_busy2, 1'b1);

        // Zero register
        chk_addr1 = 5'd0;
        wb(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234, 2'b10);
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        chk("rsv_r0", rsv_ready, 1'b1);
        chk("busy_r0", chk_busy1, 1'b0);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("busy_r0_after", chk_busy1, 1'b0);

        // Async reset with r3 busy and a write to r10 staged
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        tick();
        rsv_addr = 5'd10;
        wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        chk("rsv_r10", rsv_ready, 1'b1);
        tick();
        rsv_valid = 1'b0;
        wb(2'b01, 5'd10, 32'hAAAA5555, 5'd0, 32'h0, 2'b01);
        tick();
        req_valid = 2'b00; chk_addr1 = 5'd3;
        #1;
        chk("busy_r3_pre_reset", chk_busy1, 1'b1);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("arst_rf_we", rf_we, 1'b0);
        chk("arst_rf_wa", rf_wa, '0);
        chk("arst_rf_wd", rf_wd, '0);
        chk("arst_busy_r3", chk_busy1, 1'b0);
        chk("arst_busy_r9", chk_busy2, 1'b0);
        chk("arst_req_ready", req_ready, 2'b00);
        @(negedge clk);
        #1;
        chk("arst_negedge_we", rf_we, 1'b0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
